// File: rtl/mult_seq.sv
// Sequential shift-and-add multiplier for MULT/MULTU.
// One shared adder is stepped WITHD times per product.
module adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W:0]   s
);
  assign s = {1'b0, x} + {1'b0, y};
endmodule

module mult_seq #(
  parameter int WITHD = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WITHD-1:0] a,
  input  logic [WITHD-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WITHD-1:0] hi,
  output logic [WITHD-1:0] lo
);
  localparam int CW = $clog2(WITHD);

  typedef enum logic [2:0] {
    IDLE, LOAD, RUN, FIX, DONE
  } state_t;

  state_t             state;
  logic               sgn;
  logic               neg;
  logic [WITHD-1:0]   mcand;
  logic [WITHD-1:0]   mplier;
  logic [WITHD-1:0]   acc;
  logic [CW-1:0]      cnt;
  logic [WITHD:0]     add_s;
  logic [WITHD:0]     sum;
  logic [WITHD-1:0]   mcand_abs;
  logic [WITHD-1:0]   mplier_abs;
  logic [2*WITHD-1:0] prod;
  logic [2*WITHD-1:0] prod_n;

  adder #(.W(WITHD)) u_adder (
    .x (acc),
    .y (mcand),
    .s (add_s)
  );

  assign sum = mplier[0] ? add_s : {1'b0, acc};

  // operands are raw here; magnitudes are formed in LOAD
  assign mcand_abs  = (sgn & mcand[WITHD-1])  ? -mcand  : mcand;
  assign mplier_abs = (sgn & mplier[WITHD-1]) ? -mplier : mplier;

  assign prod   = {acc, mplier};
  assign prod_n = -prod;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sgn    <= 1'b0;
      neg    <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sgn    <= is_signed;
            mcand  <= a;
            mplier <= b;
            busy   <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          neg    <= sgn & (mcand[WITHD-1] ^ mplier[WITHD-1]);
          mcand  <= mcand_abs;
          mplier <= mplier_abs;
          acc    <= '0;
          cnt    <= '0;
          state  <= RUN;
        end
        RUN: begin
          acc    <= sum[WITHD:1];
          mplier <= {sum[0], mplier[WITHD-1:1]};
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(WITHD - 1))
            state <= FIX;
        end
        FIX: begin
          {hi, lo} <= neg ? prod_n : prod;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule
